// File: rtl/feed_scheduler_if.sv
// feed_scheduler_if: front-panel, display and motor signals of the feed scheduler.
//   arm_i, disarm_i, manual_req_i      : control requests
//   interval_tens_i, interval_ones_i   : BCD interval minutes (clamped to 9 by the consumer)
//   motor_on_o, state_o                : motor drive and FSM state
//   min_tens_o .. sec_ones_o           : BCD remaining time mm:ss
//   feed_count_o                       : dispenses since reset, saturating
// Modport slave is the scheduler, modport master is whoever drives the panel.
interface feed_scheduler_if;
   logic       arm_i;
   logic       disarm_i;
   logic       manual_req_i;
   logic [3:0] interval_tens_i;
   logic [3:0] interval_ones_i;
   logic       motor_on_o;
   logic [1:0] state_o;
   logic [3:0] min_tens_o;
   logic [3:0] min_ones_o;
   logic [3:0] sec_tens_o;
   logic [3:0] sec_ones_o;
   logic [7:0] feed_count_o;

   modport slave (
      input  arm_i, disarm_i, manual_req_i, interval_tens_i, interval_ones_i,
      output motor_on_o, state_o, min_tens_o, min_ones_o, sec_tens_o, sec_ones_o,
             feed_count_o
   );

   modport master (
      output arm_i, disarm_i, manual_req_i, interval_tens_i, interval_ones_i,
      input  motor_on_o, state_o, min_tens_o, min_ones_o, sec_tens_o, sec_ones_o,
             feed_count_o
   );
endinterface

// File: rtl/feed_scheduler.sv
// feed_scheduler: countdown/dispense sequencer for the pet feeder.
// Prescales clk into ticks, runs an mm:ss BCD down-count, drives the motor for
// DISPENSE_S ticks on expiry, then reloads the latched interval.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : feed_scheduler_if.slave (panel inputs, digits, motor, state, feed count)
// Parameters: TICK_DIV (clk cycles per tick, >=2), DISPENSE_S (motor ticks, 1..15)
// Build option: define FEEDSCHED_MANUAL_EN to enable manual_req; otherwise it is
// ignored and a dispense always returns to COUNT.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | stopped, prescaler held, waiting for arm/manual
// S_COUNT  | mm:ss counting down once per tick
// S_DISP   | motor on for DISPENSE_S ticks, then return
module feed_scheduler #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int DISPENSE_S = 3
) (
   input logic             clk,
   input logic             reset,
   feed_scheduler_if.slave bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DISP  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
   logic [3:0]    ivl_t_q, ivl_t_d, ivl_o_q, ivl_o_d;
   logic [3:0]    disp_q, disp_d;
   logic          motor_q, motor_d;
   logic [7:0]    feed_q, feed_d;
   logic          tick;
   logic          go_disp;
   logic [3:0]    arm_t, arm_o;
   logic          ret_count_q;

`ifdef FEEDSCHED_MANUAL_EN
   logic ret_count_d;
   logic disp_ret_count;
`else
   logic unused_manual_req;
   assign unused_manual_req = bus.manual_req_i;
   assign ret_count_q       = 1'b1;
`endif

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign arm_t = clamp9(bus.interval_tens_i);
   assign arm_o = clamp9(bus.interval_ones_i);
   assign tick  = (state_q != S_IDLE) && (presc_q == PRE_MAX);

   always_comb begin
      state_d = state_q;
      mt_d    = mt_q;
      mo_d    = mo_q;
      st_d    = st_q;
      so_d    = so_q;
      ivl_t_d = ivl_t_q;
      ivl_o_d = ivl_o_q;
      disp_d  = disp_q;
      motor_d = motor_q;
      feed_d  = feed_q;
      go_disp = 1'b0;
`ifdef FEEDSCHED_MANUAL_EN
      ret_count_d    = ret_count_q;
      disp_ret_count = 1'b1;
`endif

      case (state_q)
         S_IDLE: begin
`ifdef FEEDSCHED_MANUAL_EN
            if (bus.manual_req_i) begin
               go_disp        = 1'b1;
               disp_ret_count = 1'b0;
            end else
`endif
            if (bus.arm_i && ((arm_t != 4'd0) || (arm_o != 4'd0))) begin
               ivl_t_d = arm_t;
               ivl_o_d = arm_o;
               mt_d    = arm_t;
               mo_d    = arm_o;
               st_d    = 4'd0;
               so_d    = 4'd0;
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (tick) begin
               // Borrow cascade: each digit wraps only when all lower digits are 0.
               if (so_q != 4'd0) begin
                  so_d = so_q - 4'd1;
               end else begin
                  so_d = 4'd9;
                  if (st_q != 4'd0) begin
                     st_d = st_q - 4'd1;
                  end else begin
                     st_d = 4'd5;
                     if (mo_q != 4'd0) begin
                        mo_d = mo_q - 4'd1;
                     end else begin
                        mo_d = 4'd9;
                        mt_d = mt_q - 4'd1;
                     end
                  end
               end
               if ((mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1)) begin
                  go_disp = 1'b1;
               end
            end
`ifdef FEEDSCHED_MANUAL_EN
            // A manual request on a non-tick cycle freezes the digits; on an
            // expiry tick it merges into the same dispense.
            if (bus.manual_req_i) begin
               go_disp = 1'b1;
               if (!tick) begin
                  mt_d = mt_q;
                  mo_d = mo_q;
                  st_d = st_q;
                  so_d = so_q;
               end
            end
`endif
         end
         S_DISP: begin
            if (tick) begin
               if (disp_q == 4'd1) begin
                  disp_d  = 4'd0;
                  motor_d = 1'b0;
                  if (ret_count_q) begin
                     state_d = S_COUNT;
                     mt_d    = ivl_t_q;
                     mo_d    = ivl_o_q;
                     st_d    = 4'd0;
                     so_d    = 4'd0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  disp_d = disp_q - 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (go_disp) begin
         state_d = S_DISP;
         disp_d  = 4'(DISPENSE_S);
         motor_d = 1'b1;
         if (feed_q != 8'hFF) feed_d = feed_q + 8'd1;
`ifdef FEEDSCHED_MANUAL_EN
         ret_count_d = disp_ret_count;
`endif
      end

      if (bus.disarm_i) begin
         state_d = S_IDLE;
         motor_d = 1'b0;
         disp_d  = 4'd0;
         mt_d    = 4'd0;
         mo_d    = 4'd0;
         st_d    = 4'd0;
         so_d    = 4'd0;
         feed_d  = feed_q;
      end

      // Prescaler restarts on every state change so each phase starts a fresh tick.
      if ((state_d != state_q) || (state_d == S_IDLE)) begin
         presc_d = '0;
      end else if (presc_q == PRE_MAX) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         mt_q    <= 4'd0;
         mo_q    <= 4'd0;
         st_q    <= 4'd0;
         so_q    <= 4'd0;
         ivl_t_q <= 4'd0;
         ivl_o_q <= 4'd0;
         disp_q  <= 4'd0;
         motor_q <= 1'b0;
         feed_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         mt_q    <= mt_d;
         mo_q    <= mo_d;
         st_q    <= st_d;
         so_q    <= so_d;
         ivl_t_q <= ivl_t_d;
         ivl_o_q <= ivl_o_d;
         disp_q  <= disp_d;
         motor_q <= motor_d;
         feed_q  <= feed_d;
      end
   end

`ifdef FEEDSCHED_MANUAL_EN
   always_ff @(posedge clk) begin
      if (reset) ret_count_q <= 1'b0;
      else       ret_count_q <= ret_count_d;
   end
`endif

   assign bus.motor_on_o   = motor_q;
   assign bus.state_o      = state_q;
   assign bus.min_tens_o   = mt_q;
   assign bus.min_ones_o   = mo_q;
   assign bus.sec_tens_o   = st_q;
   assign bus.sec_ones_o   = so_q;
   assign bus.feed_count_o = feed_q;

endmodule

// File: tb/tb_feed_scheduler.sv
module tb_feed_scheduler;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   typedef struct {
      string       name;
      logic [26:0] v;
   } exp_t;
   exp_t sb[$];

   feed_scheduler_if bus ();
   feed_scheduler #(.TICK_DIV(4), .DISPENSE_S(2)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // {state, mm:ss digits, motor, feed_count}
   function automatic logic [26:0] pack(input logic [1:0] s, input logic [3:0] mt, mo, st, so,
                                        input logic m, input logic [7:0] fc);
      return {s, mt, mo, st, so, m, fc};
   endfunction

   function automatic logic [26:0] obs();
      return pack(bus.state_o, bus.min_tens_o, bus.min_ones_o, bus.sec_tens_o,
                  bus.sec_ones_o, bus.motor_on_o, bus.feed_count_o);
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(3);
      reset = 1'b0;
   endtask

   task automatic do_arm(input logic [3:0] t, input logic [3:0] o);
      bus.arm_i = 1'b1;
      bus.interval_tens_i = t;
      bus.interval_ones_i = o;
      cyc(1);
      bus.arm_i = 1'b0;
   endtask

   task automatic do_disarm();
      bus.disarm_i = 1'b1;
      cyc(1);
      bus.disarm_i = 1'b0;
   endtask

   task automatic count_motor(output int n);
      n = 0;
      for (int i = 0; i < 20 && bus.motor_on_o === 1'b1; i++) begin
         n++;
         cyc(1);
      end
   endtask

   task automatic test_reset();
      exp_t e;
      logic [26:0] o;
      do_reset();
      sb.push_back('{"reset_idle", pack(2'd0, 0, 0, 0, 0, 1'b0, 8'd0)});
      cyc(20);
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
   endtask

   task automatic test_basic();
      exp_t e;
      logic [26:0] o;
      int n;
      do_reset();
      sb.push_back('{"arm01_load", pack(2'd1, 0, 1, 0, 0, 1'b0, 8'd0)});
      sb.push_back('{"arm01_first_dec", pack(2'd1, 0, 0, 5, 9, 1'b0, 8'd0)});
      sb.push_back('{"arm01_expire", pack(2'd2, 0, 0, 0, 0, 1'b1, 8'd1)});
      sb.push_back('{"arm01_reload", pack(2'd1, 0, 1, 0, 0, 1'b0, 8'd1)});
      do_arm(4'd0, 4'd1);
      for (int k = 0; k < 3; k++) begin
         e = sb.pop_front(); o = obs(); total++;
         if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
         cyc(k == 0 ? 4 : (k == 1 ? 236 : 0));
      end
      count_motor(n);
      total++;
      if (n !== 8) begin bad++; $display("FAIL arm01_motor_cycles: got %0d expected 8", n); end
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
      do_disarm();
   endtask

   task automatic test_wrap();
      exp_t e;
      logic [26:0] o;
      do_reset();
      sb.push_back('{"wrap12_1tick", pack(2'd1, 1, 1, 5, 9, 1'b0, 8'd0)});
      sb.push_back('{"wrap12_41ticks", pack(2'd1, 1, 1, 1, 9, 1'b0, 8'd0)});
      sb.push_back('{"wrap10_min_ones", pack(2'd1, 0, 9, 5, 9, 1'b0, 8'd0)});
      do_arm(4'd1, 4'd2);
      cyc(4);
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
      cyc(160);
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
      do_disarm();
      do_arm(4'd1, 4'd0);
      bus.interval_tens_i = 4'd3;   // must not matter after arming
      cyc(4);
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
      do_disarm();
   endtask

   task automatic test_manual();
      exp_t e;
      logic [26:0] o;
      int n;
      do_reset();
`ifdef FEEDSCHED_MANUAL_EN
      sb.push_back('{"manual_entry", pack(2'd2, 0, 0, 0, 0, 1'b1, 8'd1)});
      sb.push_back('{"manual_back_idle", pack(2'd0, 0, 0, 0, 0, 1'b0, 8'd1)});
`else
      sb.push_back('{"manual_ignored", pack(2'd0, 0, 0, 0, 0, 1'b0, 8'd0)});
      sb.push_back('{"manual_still_idle", pack(2'd0, 0, 0, 0, 0, 1'b0, 8'd0)});
`endif
      bus.manual_req_i = 1'b1;
      cyc(1);
      bus.manual_req_i = 1'b0;
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
      count_motor(n);
      total++;
`ifdef FEEDSCHED_MANUAL_EN
      if (n !== 8) begin bad++; $display("FAIL manual_motor_cycles: got %0d expected 8", n); end
`else
      if (n !== 0) begin bad++; $display("FAIL manual_motor_cycles: got %0d expected 0", n); end
`endif
      cyc(2);
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
   endtask

   task automatic test_disarm();
      exp_t e;
      logic [26:0] o;
      do_reset();
      sb.push_back('{"disp_third_cycle", pack(2'd2, 0, 0, 0, 0, 1'b1, 8'd1)});
      sb.push_back('{"disarm_in_disp", pack(2'd0, 0, 0, 0, 0, 1'b0, 8'd1)});
      do_arm(4'd0, 4'd1);
      cyc(242);
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
      do_disarm();
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
   endtask

   task automatic test_clamp();
      exp_t e;
      logic [26:0] o;
      do_reset();
      sb.push_back('{"arm00_ignored", pack(2'd0, 0, 0, 0, 0, 1'b0, 8'd0)});
      sb.push_back('{"armFF_clamp99", pack(2'd1, 9, 9, 0, 0, 1'b0, 8'd0)});
      do_arm(4'd0, 4'd0);
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
      do_arm(4'hF, 4'hF);
      e = sb.pop_front(); o = obs(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h expected %h", e.name, o, e.v); end
      do_disarm();
   endtask

   initial begin
      reset = 1'b1;
      bus.arm_i = 1'b0;
      bus.disarm_i = 1'b0;
      bus.manual_req_i = 1'b0;
      bus.interval_tens_i = 4'd0;
      bus.interval_ones_i = 4'd0;
      cyc(1);
      test_reset();
      test_basic();
      test_wrap();
      test_manual();
      test_disarm();
      test_clamp();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/feed_scheduler.md
# feed_scheduler

Sequencing controller for the dispenser's countdown datapath. It prescales `clk` into 1 s ticks and drives a cascaded mm:ss BCD down-count, one digit per display position. On expiry it runs the dispense motor for a fixed time, then reloads the interval. It also arbitrates a manual feed request against the automatic schedule and sits between the front-panel inputs, the 7-segment digit muxing and the motor driver.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per 1 s tick; must be ≥2.
- `DISPENSE_S`, 3: motor-on duration in ticks; range 1..15.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `arm` in 1: level-sampled; starts the automatic schedule when in IDLE.
- `disarm` in 1: aborts any activity and returns to IDLE.
- `manual_req` in 1: request an immediate dispense.
- `interval_tens` in 4: BCD minutes tens; values >9 clamp to 9.
- `interval_ones` in 4: BCD minutes ones; values >9 clamp to 9.
- `motor_on` out 1: motor drive.
- `state` out 2: IDLE=0, COUNT=1, DISPENSE=2.
- `min_tens` out 4: BCD remaining-time digit.
- `min_ones` out 4: BCD remaining-time digit.
- `sec_tens` out 4: BCD remaining-time digit.
- `sec_ones` out 4: BCD remaining-time digit.
- `feed_count` out 8: dispenses since reset; saturates at 255.

## Operation
- All outputs are registered.
- Reset value of every output and internal register is 0: state IDLE, digits 00:00, motor off.
- **Prescaler**
  - Counts 0..TICK_DIV-1 in COUNT and DISPENSE and is held at 0 in IDLE.
  - Cleared on every state entry.
  - `tick` is high for one cycle when the prescaler equals TICK_DIV-1.
- **IDLE**
  - `arm` with a nonzero clamped interval: latch the interval, load digits mm:00, go to COUNT.
  - `arm` with interval 00 is ignored.
  - `manual_req`: go to DISPENSE with return target IDLE.
- **COUNT**, on each tick the cascade decrements:
  - `sec_ones` 0 wraps to 9 and borrows.
  - `sec_tens` 0 wraps to 5 and borrows.
  - `min_ones` 0 wraps to 9 and borrows.
  - `min_tens` decrements.
  - A tick at 00:01 writes 00:00 and enters DISPENSE on the same edge, with return target COUNT.
  - `manual_req` enters DISPENSE with return target COUNT; the digits are frozen.
- **DISPENSE**
  - `motor_on`=1 throughout.
  - Internal tick counter loads DISPENSE_S on entry and decrements per tick.
  - On the tick that takes it to 0: motor off, go to the return target.
  - Return to COUNT reloads the latched interval as mm:00.
  - Return to IDLE leaves the digits at 00:00.
  - `feed_count` increments on DISPENSE entry and saturates at 255.
- **Priority** within one cycle: reset > disarm > expiry > manual_req > arm.
  - `disarm` in any state: IDLE next edge, motor off, digits 00:00; `feed_count` kept.
  - `manual_req` or `arm` during DISPENSE is ignored; there is no queuing.
  - Expiry and `manual_req` in the same cycle produce a single dispense.
- `interval_*` changes after arming have no effect until the next arm.

## Timing
- IDLE→COUNT latency: 1 cycle after `arm` is sampled.
- First decrement occurs TICK_DIV cycles after COUNT entry.
- A full interval of M minutes lasts exactly M·60·TICK_DIV cycles from COUNT entry to DISPENSE entry.
- `motor_on` is high for exactly DISPENSE_S·TICK_DIV cycles, starting the cycle after the entry edge.
- `motor_on` is never high outside DISPENSE.
- Reset mid-operation takes effect at the next edge; the motor drops in the same cycle that `state` shows IDLE.

## Configuration
- Macro: `FEEDSCHED_MANUAL_EN`.
- **Defined:** `manual_req` behaves as above.
- **Undefined:**
  - `manual_req` is ignored in all states and its logic is removed.
  - DISPENSE is entered only on expiry.
  - The return target is always COUNT.

## Test plan
All scenarios use TICK_DIV=4, DISPENSE_S=2.
- Reset, then idle 20 cycles -> all outputs 0, state 0.
- Arm with interval 0/1 -> digits 01:00 next cycle; 00:59 after 4 cycles; DISPENSE at cycle 240 with digits 00:00; `motor_on` for 8 cycles; then COUNT with 01:00 and `feed_count`=1.
- Arm with interval 1/2, run 41 ticks -> digits 11:19; verify wraps on `sec_ones` 0→9, `sec_tens` 0→5, `min_ones` 0→9.
- IDLE `manual_req` pulse (macro defined) -> 8 cycles `motor_on`, then IDLE with 00:00 and `feed_count`=1; with macro undefined -> no response.
- `disarm` on the 3rd motor cycle -> `motor_on`=0 next edge, state 0, digits 00:00, `feed_count` unchanged.
- Arm with interval 0/0 and with tens=F/ones=F -> first ignored; second loads 99:00.
